mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the ARM core. It replaces the single-cycle controller with a Moore FSM that sequences one shared instruction/data memory and one ALU across several clock cycles per instruction. It also holds the condition flags, evaluates the condition field, and drives every mux select and write enable on the multicycle datapath.

## Interface

Parameters: none.

Ports:
- clk  in  1  system clock, all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (one clock domain)
- Instr  in  20  Instr[31:12] from the instruction register: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU in the current cycle
- PCWrite  out  1  load the PC
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load the instruction register
- ResultSrc  out  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  1  ALU A select: 0 = RD1, 1 = PC
- ALUSrcB  out  2  ALU B select: 00 = RD2, 01 = ExtImm, 10 = constant 4
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 pass-B
- ImmSrc  out  2  equal to Op
- RegSrc  out  2  {Op==01, Op==10}
- RegWrite  out  1  register file write
- BL  out  1  in BRANCH, write the link register R14

## Operation

- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH. Reset state is FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE → FETCH if CondEx = 0.
  - Otherwise, from DECODE by Op:
    - Op 01 → MEMADR.
    - Op 00 with Funct[5] = 0 → EXECR.
    - Op 00 with Funct[5] = 1 → EXECI.
    - Op 10 → BRANCH.
    - Op 11 → FETCH (undefined instruction, treated as a no-op).
  - MEMADR → MEMRD if Funct[0] = 1 (LDR), else → MEMWR.
  - MEMRD → MEMWB.
  - EXECR and EXECI → ALUWB, except CMP (cmd 1010), which goes → FETCH.
  - MEMWB, MEMWR, ALUWB and BRANCH → FETCH.
- Per-state outputs. Any signal not listed is 0.
  - FETCH: IRWrite = 1, PCWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ADD, ResultSrc = 10.
  - DECODE: ALUSrcA = 1, ALUSrcB = 10, ADD, ResultSrc = 10 (computes PC+8 for R15 reads).
  - MEMADR: ALUSrcB = 01, ADD.
  - MEMRD: AdrSrc = 1, ResultSrc = 00.
  - MEMWB: ResultSrc = 01, RegWrite = 1.
  - MEMWR: AdrSrc = 1, MemWrite = 1.
  - EXECR: ALUSrcB = 00, ALU op from decode.
  - EXECI: ALUSrcB = 01, ALU op from decode.
  - ALUWB: ResultSrc = 00, RegWrite = 1.
  - BRANCH: ALUSrcB = 01, ADD, ResultSrc = 10, PCWrite = 1, BL = Funct[4] (L bit), RegWrite = Funct[4].
- ALU decode by cmd = Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (uses SUB), 1101 MOV (pass-B).
  - Any other cmd → ADD, with RegWrite suppressed in ALUWB.
- Writes to PC via Rd = 15: in MEMWB or ALUWB, PCWrite = 1 when Rd = 1111.
- Flags register:
  - 4 bits, cleared by reset.
  - Updated on the rising edge that leaves EXECR or EXECI, only if the S bit Funct[0] = 1.
  - N and Z are always updated; C and V are updated only for ADD, SUB or CMP.
  - CMP always updates all four flags.
- CondEx is evaluated combinationally from Cond and the stored flags: standard ARM EQ through LE, 1110 AL = 1, 1111 = 0.

## Timing

- Latency from the FETCH cycle to the last cycle of the instruction:
  - LDR: 5 cycles.
  - STR: 4 cycles.
  - Data-processing: 4 cycles (CMP: 3).
  - Branch: 3 cycles.
  - Condition failed: 2 cycles.
- Outputs are a pure function of the state, the registered IR and the stored flags. There is no combinational path from ALUFlags to any output.
- While reset is low:
  - state = FETCH and flags = 0.
  - PCWrite, IRWrite, RegWrite, MemWrite and BL are forced to 0.
  - Mux selects hold their FETCH values.
- Reset deassertion: the first rising edge after reset goes high performs the FETCH transfer.
- Reset asserted mid-instruction: the FSM returns to FETCH immediately. No partial write occurs after assertion.
- A flag update and a state change on the same edge are consistent. An instruction entering DECODE sees flags written by the previous instruction.

## Test plan

- Reset low for 3 cycles, then high → all enables 0 during reset; first cycle after release shows IRWrite = 1, PCWrite = 1, state FETCH → DECODE.
- LDR (Instr E5900004) → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite = 1 only in MEMWB; AdrSrc = 1 in MEMRD.
- SUBS R1,R1,R1 with ALUFlags = 0100, then BEQ (0A000002) → Z latched; BEQ reaches BRANCH with PCWrite = 1.
- CMP setting Z = 0, then ADDEQ → DECODE → FETCH in 2 cycles; RegWrite, MemWrite and PCWrite (outside FETCH) stay 0.
- BL (EB000001) → BRANCH cycle has BL = 1, RegWrite = 1, PCWrite = 1, ALUSrcB = 01.
- Reset pulsed low during MEMWR of STR → MemWrite drops in the same cycle; the FSM restarts at FETCH; flags read 0000.

Source files
------------

// File: rtl/mc_if.sv
// mc_if: control bundle between the multicycle controller and its datapath
interface mc_if;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [2:0]  ALUControl;
    logic [1:0]  ImmSrc;
    logic [1:0]  RegSrc;
    logic        RegWrite;
    logic        BL;
    modport master (
        input  Instr, ALUFlags,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, BL
    );
    modport slave (
        output Instr, ALUFlags,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegSrc, RegWrite, BL
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: Moore FSM sequencing the multicycle ARM datapath, with flags and condition check
module mc_controller (
    input logic clk,
    input logic reset,
    mc_if.master bus
);
    typedef enum logic [3:0] {FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH} state_t;
    state_t state, next;
    logic [3:0] cond, rd, cmd, flags;
    logic [1:0] op, rs, sb;
    logic [5:0] funct;
    logic [2:0] alu_op, alu;
    logic known, is_cmp, cv_upd, cond_ex, pcw, adr, mw, irw, sa, rw, bl;
    logic unused_rn;
    assign cond = bus.Instr[19:16];
    assign op = bus.Instr[15:14];
    assign funct = bus.Instr[13:8];
    assign rd = bus.Instr[3:0];
    assign cmd = funct[4:1];
    assign unused_rn = ^bus.Instr[7:4];
    assign is_cmp = cmd == 4'b1010;
    assign cv_upd = cmd == 4'b0100 || cmd == 4'b0010 || is_cmp;
    always_comb begin
        alu_op = 3'b000;
        known = 1'b1;
        case (cmd)
            4'b0100: alu_op = 3'b000;
            4'b0010, 4'b1010: alu_op = 3'b001;
            4'b0000: alu_op = 3'b010;
            4'b1100: alu_op = 3'b011;
            4'b1101: alu_op = 3'b100;
            default: known = 1'b0;
        endcase
    end
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'h0: cond_ex = flags[2];
            4'h1: cond_ex = !flags[2];
            4'h2: cond_ex = flags[1];
            4'h3: cond_ex = !flags[1];
            4'h4: cond_ex = flags[3];
            4'h5: cond_ex = !flags[3];
            4'h6: cond_ex = flags[0];
            4'h7: cond_ex = !flags[0];
            4'h8: cond_ex = flags[1] && !flags[2];
            4'h9: cond_ex = !flags[1] || flags[2];
            4'hA: cond_ex = flags[3] == flags[0];
            4'hB: cond_ex = flags[3] != flags[0];
            4'hC: cond_ex = !flags[2] && (flags[3] == flags[0]);
            4'hD: cond_ex = flags[2] || (flags[3] != flags[0]);
            4'hE: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= FETCH;
        else state <= next;
    // CMP always sets flags; logical ops leave C and V alone
    always_ff @(posedge clk or negedge reset)
        if (!reset) flags <= 4'b0000;
        else if ((state == EXECR || state == EXECI) && (funct[0] || is_cmp)) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (cv_upd) flags[1:0] <= bus.ALUFlags[1:0];
        end
    always_comb begin
        next = FETCH;
        pcw = 1'b0;
        adr = 1'b0;
        mw = 1'b0;
        irw = 1'b0;
        rs = 2'b00;
        sa = 1'b0;
        sb = 2'b00;
        alu = 3'b000;
        rw = 1'b0;
        bl = 1'b0;
        case (state)
            FETCH: begin
                next = DECODE;
                irw = 1'b1;
                pcw = 1'b1;
                sa = 1'b1;
                sb = 2'b10;
                rs = 2'b10;
            end
            DECODE: begin
                sa = 1'b1;
                sb = 2'b10;
                rs = 2'b10;
                next = !cond_ex ? FETCH : op == 2'b01 ? MEMADR :
                       op == 2'b00 ? (funct[5] ? EXECI : EXECR) : op == 2'b10 ? BRANCH : FETCH;
            end
            MEMADR: begin
                sb = 2'b01;
                next = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr = 1'b1;
                next = MEMWB;
            end
            MEMWB: begin
                rs = 2'b01;
                rw = 1'b1;
                pcw = rd == 4'hF;
            end
            MEMWR: begin
                adr = 1'b1;
                mw = 1'b1;
            end
            EXECR, EXECI: begin
                sb = state == EXECI ? 2'b01 : 2'b00;
                alu = alu_op;
                next = is_cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                rw = known;
                pcw = known && rd == 4'hF;
            end
            BRANCH: begin
                sb = 2'b01;
                rs = 2'b10;
                pcw = 1'b1;
                bl = funct[4];
                rw = funct[4];
            end
            default: next = FETCH;
        endcase
    end
    assign bus.PCWrite = pcw & reset;
    assign bus.IRWrite = irw & reset;
    assign bus.RegWrite = rw & reset;
    assign bus.MemWrite = mw & reset;
    assign bus.BL = bl & reset;
    assign bus.AdrSrc = adr;
    assign bus.ResultSrc = rs;
    assign bus.ALUSrcA = sa;
    assign bus.ALUSrcB = sb;
    assign bus.ALUControl = alu;
    assign bus.ImmSrc = op;
    assign bus.RegSrc = {op == 2'b01, op == 2'b10};
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed instruction sequences checked against a queue of expected control vectors
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    mc_if bus();
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus));
    typedef struct {string tag; logic [17:0] v;} exp_t;
    exp_t sbq[$];
    int n_assert = 0;
    int n_fail = 0;
    function automatic logic [17:0] vec(input logic pcw, adr, mw, irw, input logic [1:0] rs,
                                        input logic sa, input logic [1:0] sb, input logic [2:0] alu,
                                        input logic rw, bl);
        logic [1:0] op;
        op = bus.Instr[15:14];
        return {pcw, adr, mw, irw, rs, sa, sb, alu, op, op == 2'b01, op == 2'b10, rw, bl};
    endfunction
    function automatic logic [17:0] obs();
        return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUControl, bus.ImmSrc, bus.RegSrc, bus.RegWrite, bus.BL};
    endfunction
    task automatic push(input string tag, input logic [17:0] v);
        sbq.push_back('{tag, v});
    endtask
    task automatic push_fd(input string tag);
        push({tag, "_fetch"}, vec(1, 0, 0, 1, 2'b10, 1, 2'b10, 3'b000, 0, 0));
        push({tag, "_decode"}, vec(0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0, 0));
    endtask
    task automatic push_rst(input string tag);
        push(tag, vec(0, 0, 0, 0, 2'b10, 1, 2'b10, 3'b000, 0, 0));
    endtask
    task automatic chk();
        exp_t e;
        n_assert++;
        if (sbq.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %b expected none", obs());
        end else begin
            e = sbq.pop_front();
            assert (obs() === e.v) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs(), e.v);
            end
        end
    endtask
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            chk();
            @(posedge clk);
            #1;
        end
    endtask
    task automatic set(input logic [19:0] ins, input logic [3:0] fl);
        bus.Instr = ins;
        bus.ALUFlags = fl;
    endtask
    initial begin
        set(20'hE5900, 4'h0);
        repeat (3) push_rst("reset_hold");
        cycles(3);
        reset = 1'b1;
        push_fd("ldr");
        push("ldr_memadr", vec(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 0));
        push("ldr_memrd", vec(0, 1, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        push("ldr_memwb", vec(0, 0, 0, 0, 2'b01, 0, 2'b00, 3'b000, 1, 0));
        cycles(5);
        set(20'hE0511, 4'b0100);
        push_fd("subs");
        push("subs_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b001, 0, 0));
        push("subs_aluwb", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0));
        cycles(4);
        set(20'h0A000, 4'h0);
        push_fd("beq");
        push("beq_branch", vec(1, 0, 0, 0, 2'b10, 0, 2'b01, 3'b000, 0, 0));
        cycles(3);
        set(20'hE1510, 4'b0011);
        push_fd("cmp");
        push("cmp_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b001, 0, 0));
        cycles(3);
        set(20'h00811, 4'h0);
        push_fd("addeq_skip");
        cycles(2);
        set(20'h20811, 4'h0);
        push_fd("addcs");
        push("addcs_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        push("addcs_aluwb", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0));
        cycles(4);
        set(20'hE0111, 4'b1100);
        push_fd("ands");
        push("ands_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b010, 0, 0));
        push("ands_aluwb", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0));
        cycles(4);
        set(20'h60811, 4'h0);
        push_fd("addvs");
        push("addvs_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        push("addvs_aluwb", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0));
        cycles(4);
        set(20'hE3A0F, 4'h0);
        push_fd("movpc");
        push("movpc_execi", vec(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b100, 0, 0));
        push("movpc_aluwb", vec(1, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0));
        cycles(4);
        set(20'hEC000, 4'h0);
        push_fd("undef");
        cycles(2);
        set(20'hE0221, 4'h0);
        push_fd("eor");
        push("eor_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        push("eor_aluwb", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        cycles(4);
        set(20'hEB000, 4'hF);
        push_fd("bl");
        push("bl_branch", vec(1, 0, 0, 0, 2'b10, 0, 2'b01, 3'b000, 1, 1));
        cycles(3);
        set(20'hE0511, 4'b0100);
        push_fd("subs2");
        push("subs2_execr", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b001, 0, 0));
        push("subs2_aluwb", vec(0, 0, 0, 0, 2'b00, 0, 2'b00, 3'b000, 1, 0));
        cycles(4);
        set(20'hE5801, 4'h0);
        push_fd("str");
        push("str_memadr", vec(0, 0, 0, 0, 2'b00, 0, 2'b01, 3'b000, 0, 0));
        cycles(3);
        push("str_memwr", vec(0, 1, 1, 0, 2'b00, 0, 2'b00, 3'b000, 0, 0));
        @(negedge clk);
        chk();
        #1 reset = 1'b0;
        #1;
        push_rst("str_reset_drop");
        chk();
        @(posedge clk);
        #1;
        push_rst("str_reset_hold");
        cycles(1);
        reset = 1'b1;
        set(20'h0A000, 4'h0);
        push_fd("beq_after_reset");
        push("beq_after_reset_refetch", vec(1, 0, 0, 1, 2'b10, 1, 2'b10, 3'b000, 0, 0));
        cycles(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
